// File: rtl/rom_arb_pkg.sv
// Shared types and default constants for the program-ROM port arbiter.
package rom_arb_pkg;

   typedef enum logic [1:0] {IDLE, WRITE, ADDR, DATA} state_e;

   typedef enum logic {OWN_CPU, OWN_SND} owner_e;

   localparam logic [15:0] DEF_CPU_BASE = 16'h0000;
   localparam logic [15:0] DEF_SND_BASE = 16'h8000;

endpackage

// File: rtl/rom_arb_dlbuf.sv
// One-entry buffer for ioctl download writes; flags any strobe that finds it occupied.
module rom_arb_dlbuf
   import rom_arb_pkg::*;
#(
   parameter int unsigned AW = 16,
   parameter int unsigned DW = 8
) (
   input  logic          i_clk_sys,
   input  logic          i_reset_n,
   input  logic          i_dl_active,
   input  logic          i_dl_wr,
   input  logic [AW-1:0] i_dl_addr,
   input  logic [DW-1:0] i_dl_data,
   input  logic          i_drain,
   output logic          o_full,
   output logic [AW-1:0] o_addr,
   output logic [DW-1:0] o_data,
   output logic          o_overrun
);

   logic          r_full;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_data;
   logic          r_overrun;
   logic          r_active_q;
   logic          w_load;
   logic          w_drop;
   logic          w_rise;

   // A strobe landing on the drain cycle refills the slot the arbiter is emptying.
   assign w_load = i_dl_wr & (~r_full | i_drain);
   assign w_drop = i_dl_wr & r_full & ~i_drain;
   assign w_rise = i_dl_active & ~r_active_q;

   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_full     <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_overrun  <= 1'b0;
         r_active_q <= 1'b0;
      end else begin
         r_active_q <= i_dl_active;
         if (w_load) begin
            r_full <= 1'b1;
            r_addr <= i_dl_addr;
            r_data <= i_dl_data;
         end else if (i_drain) begin
            r_full <= 1'b0;
         end
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (w_rise) begin
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_full    = r_full;
   assign o_addr    = r_addr;
   assign o_data    = r_data;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares the single program-ROM port between download writes and two round-robin CPU readers.
module rom_port_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned   AW       = 16,
   parameter int unsigned   DW       = 8,
   parameter int unsigned   CPU_AW   = 15,
   parameter int unsigned   SND_AW   = 14,
   parameter logic [AW-1:0] CPU_BASE = AW'(DEF_CPU_BASE),
   parameter logic [AW-1:0] SND_BASE = AW'(DEF_SND_BASE)
) (
   input  logic              i_clk_sys,
   input  logic              i_reset_n,
   input  logic              i_dl_active,
   input  logic              i_dl_wr,
   input  logic [AW-1:0]     i_dl_addr,
   input  logic [DW-1:0]     i_dl_data,
   output logic              o_dl_overrun,
   input  logic              i_cpu_req,
   input  logic [CPU_AW-1:0] i_cpu_addr,
   output logic              o_cpu_ack,
   output logic [DW-1:0]     o_cpu_do,
   input  logic              i_snd_req,
   input  logic [SND_AW-1:0] i_snd_addr,
   output logic              o_snd_ack,
   output logic [DW-1:0]     o_snd_do,
   output logic [AW-1:0]     o_mem_addr,
   output logic              o_mem_we,
   output logic [DW-1:0]     o_mem_d,
   input  logic [DW-1:0]     i_mem_q
);

   state_e        r_state,    w_state_nxt;
   owner_e        r_owner,    w_owner_nxt;
   owner_e        r_rr_last,  w_rr_nxt;
   logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
   logic          r_mem_we,   w_mem_we_nxt;
   logic [DW-1:0] r_mem_d,    w_mem_d_nxt;
   logic          r_cpu_ack,  w_cpu_ack_nxt;
   logic          r_snd_ack,  w_snd_ack_nxt;
   logic [DW-1:0] r_cpu_do,   w_cpu_do_nxt;
   logic [DW-1:0] r_snd_do,   w_snd_do_nxt;

   logic          w_drain;
   logic          w_buf_full;
   logic [AW-1:0] w_buf_addr;
   logic [DW-1:0] w_buf_data;
   logic [AW-1:0] w_cpu_maddr;
   logic [AW-1:0] w_snd_maddr;

   assign w_cpu_maddr = CPU_BASE + AW'(i_cpu_addr);
   assign w_snd_maddr = SND_BASE + AW'(i_snd_addr);

   rom_arb_dlbuf #(
      .AW (AW),
      .DW (DW)
   ) u_dlbuf (
      .i_clk_sys   (i_clk_sys),
      .i_reset_n   (i_reset_n),
      .i_dl_active (i_dl_active),
      .i_dl_wr     (i_dl_wr),
      .i_dl_addr   (i_dl_addr),
      .i_dl_data   (i_dl_data),
      .i_drain     (w_drain),
      .o_full      (w_buf_full),
      .o_addr      (w_buf_addr),
      .o_data      (w_buf_data),
      .o_overrun   (o_dl_overrun)
   );

   always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_owner    <= OWN_CPU;
         r_rr_last  <= OWN_SND;
         r_mem_addr <= '0;
         r_mem_we   <= 1'b0;
         r_mem_d    <= '0;
         r_cpu_ack  <= 1'b0;
         r_snd_ack  <= 1'b0;
         r_cpu_do   <= '0;
         r_snd_do   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_last  <= w_rr_nxt;
         r_mem_addr <= w_mem_addr_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_mem_d    <= w_mem_d_nxt;
         r_cpu_ack  <= w_cpu_ack_nxt;
         r_snd_ack  <= w_snd_ack_nxt;
         r_cpu_do   <= w_cpu_do_nxt;
         r_snd_do   <= w_snd_do_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_rr_nxt       = r_rr_last;
      w_mem_addr_nxt = r_mem_addr;
      w_mem_we_nxt   = 1'b0;
      w_mem_d_nxt    = r_mem_d;
      w_cpu_ack_nxt  = 1'b0;
      w_snd_ack_nxt  = 1'b0;
      w_cpu_do_nxt   = r_cpu_do;
      w_snd_do_nxt   = r_snd_do;
      w_drain        = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_buf_full) begin
               w_drain        = 1'b1;
               w_state_nxt    = WRITE;
               w_mem_addr_nxt = w_buf_addr;
               w_mem_d_nxt    = w_buf_data;
               w_mem_we_nxt   = 1'b1;
            end else if (!i_dl_active && (i_cpu_req || i_snd_req)) begin
               w_state_nxt = ADDR;
               // On a tie the requester not served last wins.
               if (i_cpu_req && (!i_snd_req || r_rr_last == OWN_SND)) begin
                  w_owner_nxt    = OWN_CPU;
                  w_mem_addr_nxt = w_cpu_maddr;
               end else begin
                  w_owner_nxt    = OWN_SND;
                  w_mem_addr_nxt = w_snd_maddr;
               end
            end
         end
         WRITE: w_state_nxt = IDLE;
         ADDR:  w_state_nxt = DATA;
         DATA: begin
            if (r_owner == OWN_CPU) begin
               w_cpu_do_nxt  = i_mem_q;
               w_cpu_ack_nxt = 1'b1;
            end else begin
               w_snd_do_nxt  = i_mem_q;
               w_snd_ack_nxt = 1'b1;
            end
            w_rr_nxt    = r_owner;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign o_mem_addr = r_mem_addr;
   assign o_mem_we   = r_mem_we;
   assign o_mem_d    = r_mem_d;
   assign o_cpu_ack  = r_cpu_ack;
   assign o_snd_ack  = r_snd_ack;
   assign o_cpu_do   = r_cpu_do;
   assign o_snd_do   = r_snd_do;

endmodule
